// File: rtl/reg_file_param.sv
// rtl/reg_file_param.sv - parametrised register file with write bypass, zero register and pending scoreboard
module reg_file_param #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rsv,
    input  logic [ADDR_W-1:0] rsv_addr,
    input  logic [ADDR_W-1:0] rs1_addr,
    input  logic [ADDR_W-1:0] rs2_addr,
    output logic [DATA_W-1:0] rs1_data,
    output logic [DATA_W-1:0] rs2_data,
    output logic              rs1_busy,
    output logic              rs2_busy,
    output logic              any_pending
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] rf [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic              wr_ok;
    logic              rsv_ok;

    assign wr_ok  = we  && !(ZERO_REG != 0 && waddr == '0);
    assign rsv_ok = rsv && !(ZERO_REG != 0 && rsv_addr == '0);

    // Reserve is applied after the write clear so a new producer wins a same-index collision.
    always_comb begin
        pending_next = pending;
        if (wr_ok) begin
            pending_next[waddr] = 1'b0;
        end
        if (rsv_ok) begin
            pending_next[rsv_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                rf[i] <= '0;
            end
            pending <= '0;
        end else begin
            if (wr_ok) begin
                rf[waddr] <= wdata;
            end
            pending <= pending_next;
        end
    end

    always_comb begin
        rs1_data = rf[rs1_addr];
        rs1_busy = pending[rs1_addr];
        if (BYPASS != 0 && wr_ok && waddr == rs1_addr) begin
            rs1_data = wdata;
            rs1_busy = 1'b0;
        end
        if (ZERO_REG != 0 && rs1_addr == '0) begin
            rs1_data = '0;
            rs1_busy = 1'b0;
        end
    end

    always_comb begin
        rs2_data = rf[rs2_addr];
        rs2_busy = pending[rs2_addr];
        if (BYPASS != 0 && wr_ok && waddr == rs2_addr) begin
            rs2_data = wdata;
            rs2_busy = 1'b0;
        end
        if (ZERO_REG != 0 && rs2_addr == '0) begin
            rs2_data = '0;
            rs2_busy = 1'b0;
        end
    end

    // Registered state only: a same-cycle write does not drop any_pending early.
    assign any_pending = |pending;

endmodule

// File: tb/tb_reg_file_param.sv
// tb/tb_reg_file_param.sv - directed bench for reg_file_param across three parameter sets
module tb_reg_file_param;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        we = 1'b0;
    logic [3:0]  waddr = '0;
    logic [15:0] wdata = '0;
    logic        rsv = 1'b0;
    logic [3:0]  rsv_addr = '0;
    logic [3:0]  rs1_addr = '0;
    logic [3:0]  rs2_addr = '0;

    logic [15:0] a_rs1_data, a_rs2_data, b_rs1_data, b_rs2_data;
    logic        a_rs1_busy, a_rs2_busy, a_any, b_rs1_busy, b_rs2_busy, b_any;

    logic        c_we = 1'b0;
    logic [4:0]  c_waddr = '0;
    logic [31:0] c_wdata = '0;
    logic        c_rsv = 1'b0;
    logic [4:0]  c_rsv_addr = '0;
    logic [4:0]  c_rs1_addr = '0;
    logic [4:0]  c_rs2_addr = '0;
    logic [31:0] c_rs1_data, c_rs2_data;
    logic        c_rs1_busy, c_rs2_busy, c_any;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv(rsv), .rsv_addr(rsv_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(a_rs1_data), .rs2_data(a_rs2_data),
        .rs1_busy(a_rs1_busy), .rs2_busy(a_rs2_busy), .any_pending(a_any)
    );

    reg_file_param #(.DATA_W(16), .ADDR_W(4), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .clk(clk), .reset(reset), .we(we), .waddr(waddr), .wdata(wdata),
        .rsv(rsv), .rsv_addr(rsv_addr), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
        .rs1_data(b_rs1_data), .rs2_data(b_rs2_data),
        .rs1_busy(b_rs1_busy), .rs2_busy(b_rs2_busy), .any_pending(b_any)
    );

    reg_file_param #(.DATA_W(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .clk(clk), .reset(reset), .we(c_we), .waddr(c_waddr), .wdata(c_wdata),
        .rsv(c_rsv), .rsv_addr(c_rsv_addr), .rs1_addr(c_rs1_addr), .rs2_addr(c_rs2_addr),
        .rs1_data(c_rs1_data), .rs2_data(c_rs2_data),
        .rs1_busy(c_rs1_busy), .rs2_busy(c_rs2_busy), .any_pending(c_any)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2;
        check("rst_a_rs1", 32'(a_rs1_data), 32'h0);
        check("rst_a_any", 32'(a_any), 32'h0);
        check("rst_b_rs2", 32'(b_rs2_data), 32'h0);
        check("rst_c_rs1", c_rs1_data, 32'h0);

        step();
        reset = 1'b1;

        // preload rf[5] and reserve reg 7
        we = 1'b1; waddr = 4'd5; wdata = 16'h1234;
        rsv = 1'b1; rsv_addr = 4'd7;
        rs1_addr = 4'd5; rs2_addr = 4'd7;
        step();
        we = 1'b0; rsv = 1'b0;
        #1;
        check("pre_a_rs1", 32'(a_rs1_data), 32'h1234);
        check("pre_a_busy7", 32'(a_rs2_busy), 32'h1);
        check("pre_a_any", 32'(a_any), 32'h1);
        #1;
        reset = 1'b0;
        #1;
        check("async_a_rs1", 32'(a_rs1_data), 32'h0);
        check("async_a_busy7", 32'(a_rs2_busy), 32'h0);
        check("async_a_any", 32'(a_any), 32'h0);
        check("async_b_rs1", 32'(b_rs1_data), 32'h0);
        check("async_b_any", 32'(b_any), 32'h0);
        reset = 1'b1;

        // bypass vs no bypass
        step();
        we = 1'b1; waddr = 4'd3; wdata = 16'hBEEF; rs1_addr = 4'd3;
        #1;
        check("byp_a_same", 32'(a_rs1_data), 32'hBEEF);
        check("byp_b_same", 32'(b_rs1_data), 32'h0);
        step();
        we = 1'b0;
        #1;
        check("byp_a_next", 32'(a_rs1_data), 32'hBEEF);
        check("byp_b_next", 32'(b_rs1_data), 32'hBEEF);

        // register 0: hardwired in A, ordinary in B
        we = 1'b1; waddr = 4'd0; wdata = 16'hFFFF;
        rsv = 1'b1; rsv_addr = 4'd0; rs1_addr = 4'd0;
        #1;
        check("zero_a_same", 32'(a_rs1_data), 32'h0);
        check("zero_a_busy_same", 32'(a_rs1_busy), 32'h0);
        step();
        we = 1'b0; rsv = 1'b0;
        #1;
        check("zero_a_data", 32'(a_rs1_data), 32'h0);
        check("zero_a_busy", 32'(a_rs1_busy), 32'h0);
        check("zero_a_any", 32'(a_any), 32'h0);
        check("zero_b_data", 32'(b_rs1_data), 32'hFFFF);
        check("zero_b_busy", 32'(b_rs1_busy), 32'h1);
        check("zero_b_any", 32'(b_any), 32'h1);
        step();
        check("zero_a_data2", 32'(a_rs1_data), 32'h0);
        we = 1'b1; waddr = 4'd0; wdata = 16'h0000;
        step();
        we = 1'b0;
        #1;
        check("zero_b_clr_busy", 32'(b_rs1_busy), 32'h0);
        check("zero_b_clr_any", 32'(b_any), 32'h0);

        // scoreboard on reg 9
        rsv = 1'b1; rsv_addr = 4'd9; rs2_addr = 4'd9;
        #1;
        check("sb_a_busy_same", 32'(a_rs2_busy), 32'h0);
        step();
        rsv = 1'b0;
        #1;
        check("sb_a_busy", 32'(a_rs2_busy), 32'h1);
        check("sb_a_any", 32'(a_any), 32'h1);
        check("sb_b_busy", 32'(b_rs2_busy), 32'h1);
        step();
        check("sb_a_busy_hold", 32'(a_rs2_busy), 32'h1);
        we = 1'b1; waddr = 4'd9; wdata = 16'h0042;
        #1;
        check("sb_a_clr_same", 32'(a_rs2_busy), 32'h0);
        check("sb_a_data_same", 32'(a_rs2_data), 32'h0042);
        check("sb_a_any_same", 32'(a_any), 32'h1);
        check("sb_b_busy_same", 32'(b_rs2_busy), 32'h1);
        check("sb_b_data_same", 32'(b_rs2_data), 32'h0);
        step();
        we = 1'b0;
        #1;
        check("sb_a_any_after", 32'(a_any), 32'h0);
        check("sb_b_busy_after", 32'(b_rs2_busy), 32'h0);
        check("sb_b_data_after", 32'(b_rs2_data), 32'h0042);
        check("sb_b_any_after", 32'(b_any), 32'h0);

        // same-index collision: reserve wins
        we = 1'b1; waddr = 4'd4; wdata = 16'h00AA;
        rsv = 1'b1; rsv_addr = 4'd4; rs1_addr = 4'd4;
        step();
        we = 1'b0; rsv = 1'b0;
        #1;
        check("col_a_data", 32'(a_rs1_data), 32'h00AA);
        check("col_a_busy", 32'(a_rs1_busy), 32'h1);
        check("col_b_data", 32'(b_rs1_data), 32'h00AA);
        check("col_b_busy", 32'(b_rs1_busy), 32'h1);

        // different indices in one cycle: both take effect
        we = 1'b1; waddr = 4'd4; wdata = 16'h00BB;
        rsv = 1'b1; rsv_addr = 4'd6; rs2_addr = 4'd6;
        #1;
        check("dif_a_busy4_same", 32'(a_rs1_busy), 32'h0);
        check("dif_b_busy4_same", 32'(b_rs1_busy), 32'h1);
        step();
        we = 1'b0; rsv = 1'b0;
        #1;
        check("dif_a_data4", 32'(a_rs1_data), 32'h00BB);
        check("dif_a_busy4", 32'(a_rs1_busy), 32'h0);
        check("dif_a_busy6", 32'(a_rs2_busy), 32'h1);
        check("dif_b_busy6", 32'(b_rs2_busy), 32'h1);

        // wide configuration
        c_we = 1'b1; c_waddr = 5'd31; c_wdata = 32'hDEADBEEF;
        c_rs1_addr = 5'd31; c_rs2_addr = 5'd30;
        #1;
        check("wide_byp", c_rs1_data, 32'hDEADBEEF);
        step();
        c_we = 1'b0;
        #1;
        check("wide_r31", c_rs1_data, 32'hDEADBEEF);
        check("wide_r30", c_rs2_data, 32'h0);
        check("wide_any", 32'(c_any), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
